// File: rtl/uart_frame_parser.sv
// Framed-packet parser behind the UART receiver: SYNC, LEN, PAYLOAD, CSUM -> store-and-forward drain.
// Optional frame statistics counters are built when UART_FRAME_STATS_EN is defined.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 80000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 17) ? $clog2(TIMEOUT_CYCLES + 1) : 17;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    MAXL = 9'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, DRAIN} state_t;

  state_t          state;
  logic            rx_valid_q;
  logic            byte_stb;
  logic [7:0]      len, sum, idx, rd_idx;
  logic [TW-1:0]   tcnt;
  logic [7:0]      mem [MAX_LEN];

  assign byte_stb = rx_valid && !rx_valid_q;
  assign busy     = (state != HUNT);

  // payload buffer: no reset, contents are don't-care outside a frame
  always_ff @(posedge clk)
    if (state == PAYLOAD && byte_stb) mem[idx[AW-1:0]] <= rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      rx_valid_q <= 1'b1;
      len        <= '0;
      sum        <= '0;
      idx        <= '0;
      rd_idx     <= '0;
      tcnt       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      rx_valid_q <= rx_valid;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      // inter-byte watchdog only runs while a frame is being collected
      if (state inside {LEN, PAYLOAD, CSUM}) tcnt <= byte_stb ? '0 : tcnt + 1'b1;
      else                                   tcnt <= '0;

      case (state)
        HUNT:
          if (byte_stb && rx_data == SYNC_BYTE) state <= LEN;
        LEN:
          if (byte_stb) begin
            len <= rx_data;
            if (rx_data == 8'd0 || {1'b0, rx_data} > MAXL) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state     <= HUNT;
            end else begin
              sum   <= rx_data;
              idx   <= '0;
              state <= PAYLOAD;
            end
          end else if (tcnt == TLIM) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= HUNT;
          end
        PAYLOAD:
          if (byte_stb) begin
            sum <= sum + rx_data;
            idx <= idx + 8'd1;
            if (idx + 8'd1 == len) state <= CSUM;
          end else if (tcnt == TLIM) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= HUNT;
          end
        CSUM:
          if (byte_stb) begin
            if (sum + rx_data == 8'd0) begin
              frame_ok <= 1'b1;
              rd_idx   <= '0;
              state    <= DRAIN;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= HUNT;
            end
          end else if (tcnt == TLIM) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= HUNT;
          end
        DRAIN: begin
          if (byte_stb) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
          end
          // rd_idx points at the next byte to present
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= mem[0];
            out_last  <= (len == 8'd1);
            rd_idx    <= 8'd1;
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= HUNT;
            end else begin
              out_data <= mem[rd_idx[AW-1:0]];
              out_last <= (rd_idx == len - 8'd1);
              rd_idx   <= rd_idx + 8'd1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

`ifdef UART_FRAME_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_count <= '0;
      bad_count  <= '0;
    end else begin
      if (frame_ok  && good_count != 16'hFFFF) good_count <= good_count + 16'd1;
      if (frame_err && bad_count  != 16'hFFFF) bad_count  <= bad_count + 16'd1;
    end
  end
`else
  assign good_count = '0;
  assign bad_count  = '0;
`endif

endmodule
